pifo_calendar_v1_0: RTL and testbench

PIFO_CALENDAR_V1_0 -- requirements
Module: pifo_calendar_v1_0

---
 rtl/pifo_calendar_pkg.sv | 26 ++
 rtl/pifo_calendar_cell.sv | 38 +++
 rtl/pifo_calendar_v1_0.sv | 173 +++++++++++++++++
 tb/tb_pifo_calendar_v1_0.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_calendar_pkg.sv
// Shared element layout, per-slot mux operations and the rank-extract helper
// used by the PIFO calendar and its slot cells.
package pifo_calendar_pkg;

  localparam int PIFO_ELEMENT_WIDTH     = 32;
  localparam int PIFO_BUFFER_ADDR_WIDTH = 12;
  localparam int PIFO_RANK_WIDTH        = 19;
  localparam int PIFO_RANK_START_POS    = 12;
  localparam int PIFO_VALID_POS         = 31;

  typedef enum logic [2:0] {
    CELL_HOLD,
    CELL_SHIFT_IN,   // take the head-ward neighbour (insert makes room)
    CELL_SHIFT_OUT,  // take the tail-ward neighbour (pop closes the gap)
    CELL_LOAD,       // take the incoming element
    CELL_CPU_WR,
    CELL_CLEAR
  } cell_op_e;

  function automatic logic [PIFO_RANK_WIDTH-1:0] pifo_rank(
    input logic [PIFO_ELEMENT_WIDTH-1:0] e
  );
    return e[PIFO_RANK_START_POS +: PIFO_RANK_WIDTH];
  endfunction

endpackage

// File: rtl/pifo_calendar_cell.sv
// One calendar slot: holds an element, reports whether it is occupied with a
// rank <= the incoming rank, and updates from the operation chosen by the top.
module pifo_calendar_cell
  import pifo_calendar_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstn,
  input  cell_op_e                      i_op,
  input  logic [PIFO_ELEMENT_WIDTH-1:0] i_prev,
  input  logic [PIFO_ELEMENT_WIDTH-1:0] i_next,
  input  logic [PIFO_ELEMENT_WIDTH-1:0] i_new,
  input  logic [PIFO_ELEMENT_WIDTH-1:0] i_cpu,
  input  logic                          i_occ,
  input  logic [PIFO_RANK_WIDTH-1:0]    i_new_rank,
  output logic [PIFO_ELEMENT_WIDTH-1:0] o_slot,
  output logic                          o_le
);

  logic [PIFO_ELEMENT_WIDTH-1:0] r_slot;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_slot <= '0;
    else begin
      case (i_op)
        CELL_SHIFT_IN:  r_slot <= i_prev;
        CELL_SHIFT_OUT: r_slot <= i_next;
        CELL_LOAD:      r_slot <= i_new;
        CELL_CPU_WR:    r_slot <= i_cpu;
        CELL_CLEAR:     r_slot <= '0;
        default:        r_slot <= r_slot;
      endcase
    end
  end

  assign o_slot = r_slot;
  assign o_le   = i_occ && (pifo_rank(r_slot) <= i_new_rank);

endmodule

// File: rtl/pifo_calendar_v1_0.sv
// Shift-register PIFO calendar: slots kept sorted by rank (FIFO among equal
// ranks), single-cycle insert/pop/swap, bypass on empty, CPU peek/poke port.
module pifo_calendar_v1_0
  import pifo_calendar_pkg::*;
#(
  parameter int PIFO_CALENDAR_SIZE        = 64,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 6,
  parameter int ELEMENT_WIDTH             = PIFO_ELEMENT_WIDTH,
  parameter int BUFFER_ADDR_WIDTH         = PIFO_BUFFER_ADDR_WIDTH,
  parameter int RANK_WIDTH                = PIFO_RANK_WIDTH,
  parameter int RANK_START_POS            = PIFO_RANK_START_POS,
  parameter int VALID_POS                 = PIFO_VALID_POS
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [ELEMENT_WIDTH-1:0]             s_axis_pifo_info,
  input  logic                                 s_axis_insert_en,
  input  logic                                 s_axis_pop_en,
  output logic [ELEMENT_WIDTH-1:0]             m_axis_pop_data,
  output logic                                 m_axis_pop_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_buffer_addr,
  output logic                                 m_axis_bypass_en,
  output logic                                 m_axis_drop,
  output logic                                 m_axis_calendar_full,
  output logic                                 m_axis_calendar_empty,
  output logic [PIFO_CALENDAR_INDEX_WIDTH:0]   m_axis_calendar_count,
  input  logic                                 cpu_rd_valid,
  input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_rd_addr,
  output logic                                 cpu_rd_result_valid,
  output logic [ELEMENT_WIDTH-1:0]             cpu_rd_result,
  input  logic                                 cpu_wr_valid,
  output logic                                 cpu_wr_ready,
  input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr,
  input  logic [ELEMENT_WIDTH-1:0]             cpu_wr_data,
  output logic                                 cpu_wr_result_valid
);

  localparam int SZ = PIFO_CALENDAR_SIZE;
  localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
  localparam int CW = IW + 1;

  logic [SZ:0][ELEMENT_WIDTH-1:0] w_slot_x;  // entry SZ is a constant-zero tail
  logic [SZ-1:0][ELEMENT_WIDTH-1:0] w_prev;
  logic [SZ:0]                      w_le_x, w_occ_x;
  logic [SZ-1:0]                    w_lo_le, w_lo_occ;
  logic [RANK_WIDTH-1:0]            w_new_rank;

  logic [CW-1:0]            r_count;
  logic                     r_wr_ready, r_wr_result_valid;
  logic [IW-1:0]            r_wr_addr;
  logic [ELEMENT_WIDTH-1:0] r_wr_data;
  logic [ELEMENT_WIDTH-1:0] r_pop_data, r_rd_result;
  logic                     r_pop_valid, r_bypass, r_drop, r_rd_valid;

  logic w_empty, w_full, w_ins, w_pop, w_bypass, w_drop;
  logic w_ins_only, w_swap, w_pop_only, w_wr_apply;

  assign w_new_rank = s_axis_pifo_info[RANK_START_POS +: RANK_WIDTH];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(SZ));
  assign w_ins      = s_axis_insert_en & s_axis_pifo_info[VALID_POS];
  assign w_pop      = s_axis_pop_en & ~w_empty;
  assign w_bypass   = w_ins & s_axis_pop_en & w_empty;
  assign w_drop     = w_ins & ~s_axis_pop_en & w_full;
  assign w_ins_only = w_ins & ~s_axis_pop_en & ~w_full;
  assign w_swap     = w_ins & w_pop;
  assign w_pop_only = w_pop & ~w_ins;
  assign w_wr_apply = ~r_wr_ready & ~w_ins & ~w_pop;

  assign w_slot_x[SZ] = '0;
  assign w_le_x[SZ]   = 1'b0;
  assign w_occ_x[SZ]  = 1'b0;

  for (genvar i = 0; i < SZ; i++) begin : g_slot
    cell_op_e w_op;

    if (i == 0) begin : g_head
      assign w_lo_le[i]  = 1'b1;
      assign w_lo_occ[i] = 1'b1;
      assign w_prev[i]   = '0;
    end else begin : g_body
      assign w_lo_le[i]  = w_le_x[i-1];
      assign w_lo_occ[i] = w_occ_x[i-1];
      assign w_prev[i]   = w_slot_x[i-1];
    end

    assign w_occ_x[i] = (CW'(i) < r_count);

    // le bits form a prefix over occupied slots, so each slot decides locally
    always_comb begin
      w_op = CELL_HOLD;
      if (w_wr_apply && ({1'b0, r_wr_addr} == CW'(i)))
        w_op = CELL_CPU_WR;
      else if (w_ins_only && !w_le_x[i])
        w_op = w_lo_le[i] ? CELL_LOAD : (w_lo_occ[i] ? CELL_SHIFT_IN : CELL_HOLD);
      else if (w_swap)
        w_op = w_le_x[i+1] ? CELL_SHIFT_OUT :
               ((i == 0) || w_le_x[i]) ? CELL_LOAD : CELL_HOLD;
      else if (w_pop_only)
        w_op = w_occ_x[i+1] ? CELL_SHIFT_OUT : (w_occ_x[i] ? CELL_CLEAR : CELL_HOLD);
    end

    pifo_calendar_cell u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .i_op       (w_op),
      .i_prev     (w_prev[i]),
      .i_next     (w_slot_x[i+1]),
      .i_new      (s_axis_pifo_info),
      .i_cpu      (r_wr_data),
      .i_occ      (w_occ_x[i]),
      .i_new_rank (w_new_rank),
      .o_slot     (w_slot_x[i]),
      .o_le       (w_le_x[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_bypass    <= 1'b0;
      r_drop      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_result <= '0;
    end else begin
      if (w_ins_only)      r_count <= r_count + 1'b1;
      else if (w_pop_only) r_count <= r_count - 1'b1;
      r_pop_valid <= w_pop | w_bypass;
      r_bypass    <= w_bypass;
      r_drop      <= w_drop;
      if (w_bypass)   r_pop_data <= s_axis_pifo_info;
      else if (w_pop) r_pop_data <= w_slot_x[0];
      r_rd_valid <= cpu_rd_valid;
      if (cpu_rd_valid)
        r_rd_result <= ({1'b0, cpu_rd_addr} < CW'(SZ)) ? w_slot_x[cpu_rd_addr] : '0;
    end
  end

  // Single pending CPU write; it waits for a cycle with no datapath activity.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ready        <= 1'b1;
      r_wr_result_valid <= 1'b0;
      r_wr_addr         <= '0;
      r_wr_data         <= '0;
    end else begin
      r_wr_result_valid <= w_wr_apply;
      if (r_wr_ready && cpu_wr_valid) begin
        r_wr_ready <= 1'b0;
        r_wr_addr  <= cpu_wr_addr;
        r_wr_data  <= cpu_wr_data;
      end else if (w_wr_apply) begin
        r_wr_ready <= 1'b1;
      end
    end
  end

  assign m_axis_pop_data       = r_pop_data;
  assign m_axis_pop_valid      = r_pop_valid;
  assign m_axis_buffer_addr    = r_pop_data[BUFFER_ADDR_WIDTH-1:0];
  assign m_axis_bypass_en      = r_bypass;
  assign m_axis_drop           = r_drop;
  assign m_axis_calendar_full  = w_full;
  assign m_axis_calendar_empty = w_empty;
  assign m_axis_calendar_count = r_count;
  assign cpu_rd_result_valid   = r_rd_valid;
  assign cpu_rd_result         = r_rd_result;
  assign cpu_wr_ready          = r_wr_ready;
  assign cpu_wr_result_valid   = r_wr_result_valid;

endmodule

// File: tb/tb_pifo_calendar_v1_0.sv
// Directed bench for the PIFO calendar: ordering, bypass, full/drop/swap,
// drain order, CPU read/write handshake and asynchronous reset.
module tb_pifo_calendar_v1_0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_axis_pifo_info = '0;
  logic        s_axis_insert_en = 1'b0;
  logic        s_axis_pop_en = 1'b0;
  logic [31:0] m_axis_pop_data;
  logic        m_axis_pop_valid;
  logic [11:0] m_axis_buffer_addr;
  logic        m_axis_bypass_en;
  logic        m_axis_drop;
  logic        m_axis_calendar_full;
  logic        m_axis_calendar_empty;
  logic [6:0]  m_axis_calendar_count;
  logic        cpu_rd_valid = 1'b0;
  logic [5:0]  cpu_rd_addr = '0;
  logic        cpu_rd_result_valid;
  logic [31:0] cpu_rd_result;
  logic        cpu_wr_valid = 1'b0;
  logic        cpu_wr_ready;
  logic [5:0]  cpu_wr_addr = '0;
  logic [31:0] cpu_wr_data = '0;
  logic        cpu_wr_result_valid;

  int n_chk = 0;
  int n_err = 0;

  pifo_calendar_v1_0 dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .s_axis_pifo_info      (s_axis_pifo_info),
    .s_axis_insert_en      (s_axis_insert_en),
    .s_axis_pop_en         (s_axis_pop_en),
    .m_axis_pop_data       (m_axis_pop_data),
    .m_axis_pop_valid      (m_axis_pop_valid),
    .m_axis_buffer_addr    (m_axis_buffer_addr),
    .m_axis_bypass_en      (m_axis_bypass_en),
    .m_axis_drop           (m_axis_drop),
    .m_axis_calendar_full  (m_axis_calendar_full),
    .m_axis_calendar_empty (m_axis_calendar_empty),
    .m_axis_calendar_count (m_axis_calendar_count),
    .cpu_rd_valid          (cpu_rd_valid),
    .cpu_rd_addr           (cpu_rd_addr),
    .cpu_rd_result_valid   (cpu_rd_result_valid),
    .cpu_rd_result         (cpu_rd_result),
    .cpu_wr_valid          (cpu_wr_valid),
    .cpu_wr_ready          (cpu_wr_ready),
    .cpu_wr_addr           (cpu_wr_addr),
    .cpu_wr_data           (cpu_wr_data),
    .cpu_wr_result_valid   (cpu_wr_result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] elem(input logic [11:0] a, input logic [18:0] r);
    return {1'b1, r, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic ins, input logic [31:0] info, input logic pop);
    s_axis_insert_en = ins;
    s_axis_pifo_info = info;
    s_axis_pop_en    = pop;
    tick();
    s_axis_insert_en = 1'b0;
    s_axis_pop_en    = 1'b0;
    s_axis_pifo_info = '0;
  endtask

  task automatic rd(input logic [5:0] a);
    cpu_rd_valid = 1'b1;
    cpu_rd_addr  = a;
    tick();
    cpu_rd_valid = 1'b0;
  endtask

  logic [11:0] exp_a [4] = '{12'd2, 12'd4, 12'd1, 12'd3};
  logic [31:0] wr_d = 32'h1234_5678;

  initial begin
    // reset state, sampled while rstn is held low
    #12;
    chk("rst_count", 32'(m_axis_calendar_count), 32'd0);
    chk("rst_empty", 32'(m_axis_calendar_empty), 32'd1);
    chk("rst_full", 32'(m_axis_calendar_full), 32'd0);
    chk("rst_wr_ready", 32'(cpu_wr_ready), 32'd1);
    chk("rst_pop_valid", 32'(m_axis_pop_valid), 32'd0);
    chk("rst_drop", 32'(m_axis_drop), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // element with valid bit clear is ignored
    cyc(1'b1, 32'h0000_5001, 1'b0);
    chk("invalid_ins_count", 32'(m_axis_calendar_count), 32'd0);

    // ordering with equal ranks: 5,3,9,3 -> addrs 2,4,1,3
    cyc(1'b1, elem(12'd1, 19'd5), 1'b0);
    cyc(1'b1, elem(12'd2, 19'd3), 1'b0);
    cyc(1'b1, elem(12'd3, 19'd9), 1'b0);
    cyc(1'b1, elem(12'd4, 19'd3), 1'b0);
    chk("order_count", 32'(m_axis_calendar_count), 32'd4);
    rd(6'd1);
    chk("rd_valid", 32'(cpu_rd_result_valid), 32'd1);
    chk("rd_slot1", cpu_rd_result, elem(12'd4, 19'd3));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b1);
      chk("order_pop_valid", 32'(m_axis_pop_valid), 32'd1);
      chk("order_pop_addr", 32'(m_axis_buffer_addr), 32'(exp_a[k]));
    end
    chk("order_empty", 32'(m_axis_calendar_empty), 32'd1);
    cyc(1'b0, '0, 1'b1);
    chk("pop_empty_valid", 32'(m_axis_pop_valid), 32'd0);
    chk("pop_empty_count", 32'(m_axis_calendar_count), 32'd0);

    // bypass on empty insert+pop
    cyc(1'b1, elem(12'hABC, 19'd7), 1'b1);
    chk("byp_valid", 32'(m_axis_pop_valid), 32'd1);
    chk("byp_en", 32'(m_axis_bypass_en), 32'd1);
    chk("byp_addr", 32'(m_axis_buffer_addr), 32'hABC);
    chk("byp_count", 32'(m_axis_calendar_count), 32'd0);
    tick();
    chk("byp_valid_pulse", 32'(m_axis_pop_valid), 32'd0);
    chk("byp_en_pulse", 32'(m_axis_bypass_en), 32'd0);

    // fill to full, drop, then swap while full
    for (int i = 0; i < 64; i++) cyc(1'b1, elem(12'(i), 19'(2 * i)), 1'b0);
    chk("fill_count", 32'(m_axis_calendar_count), 32'd64);
    chk("fill_full", 32'(m_axis_calendar_full), 32'd1);
    cyc(1'b1, elem(12'h7FE, 19'd1), 1'b0);
    chk("drop_pulse", 32'(m_axis_drop), 32'd1);
    chk("drop_count", 32'(m_axis_calendar_count), 32'd64);
    cyc(1'b1, elem(12'h7FF, 19'd1), 1'b1);
    chk("swap_drop", 32'(m_axis_drop), 32'd0);
    chk("swap_valid", 32'(m_axis_pop_valid), 32'd1);
    chk("swap_addr", 32'(m_axis_buffer_addr), 32'd0);
    chk("swap_count", 32'(m_axis_calendar_count), 32'd64);
    cyc(1'b0, '0, 1'b1);
    chk("swap_new_head", 32'(m_axis_buffer_addr), 32'h7FF);
    chk("pop_full_count", 32'(m_axis_calendar_count), 32'd63);
    rd(6'd63);
    chk("tail_cleared", cpu_rd_result, 32'd0);
    for (int k = 1; k < 64; k++) begin
      cyc(1'b0, '0, 1'b1);
      chk("drain_addr", 32'(m_axis_buffer_addr), 32'(k));
    end
    chk("drain_empty", 32'(m_axis_calendar_empty), 32'd1);

    // CPU write deferred behind continuous inserts
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 6'd2;
    cpu_wr_data  = wr_d;
    cyc(1'b1, elem(12'd10, 19'd10), 1'b0);
    cpu_wr_valid = 1'b0;
    chk("wr_ready_low", 32'(cpu_wr_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, elem(12'(10 + i), 19'(10 * (i + 1))), 1'b0);
      chk("wr_busy_ready", 32'(cpu_wr_ready), 32'd0);
      chk("wr_busy_result", 32'(cpu_wr_result_valid), 32'd0);
    end
    tick();
    chk("wr_result_pulse", 32'(cpu_wr_result_valid), 32'd1);
    chk("wr_ready_back", 32'(cpu_wr_ready), 32'd1);
    tick();
    chk("wr_result_one", 32'(cpu_wr_result_valid), 32'd0);
    chk("wr_count_kept", 32'(m_axis_calendar_count), 32'd4);
    rd(6'd2);
    chk("wr_readback", cpu_rd_result, wr_d);

    // async reset mid-traffic with a write pending
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 6'd1;
    cpu_wr_data  = 32'hDEAD_BEEF;
    cyc(1'b1, elem(12'd14, 19'd50), 1'b0);
    cpu_wr_valid = 1'b0;
    chk("pre_rst_ready", 32'(cpu_wr_ready), 32'd0);
    cyc(1'b1, elem(12'd15, 19'd60), 1'b1);
    chk("pre_rst_pop", 32'(m_axis_buffer_addr), 32'd10);
    s_axis_insert_en = 1'b1;
    s_axis_pifo_info = elem(12'd16, 19'd70);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pop_valid", 32'(m_axis_pop_valid), 32'd0);
    chk("arst_pop_data", m_axis_pop_data, 32'd0);
    chk("arst_count", 32'(m_axis_calendar_count), 32'd0);
    chk("arst_empty", 32'(m_axis_calendar_empty), 32'd1);
    chk("arst_rd_result", cpu_rd_result, 32'd0);
    chk("arst_wr_ready", 32'(cpu_wr_ready), 32'd1);
    s_axis_insert_en = 1'b0;
    s_axis_pifo_info = '0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_wr_result", 32'(cpu_wr_result_valid), 32'd0);
    end
    rd(6'd2);
    chk("arst_slot_cleared", cpu_rd_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
